led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent LED channels (1..32).
REQ-002 Parameter CNT_W, default 16: width of per-channel period counter and cfg_period.
REQ-003 Parameter DIM_W, default 4: width of global dimming counter and dim_level.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  config write request.
REQ-007 cfg_ready  output  1  block can accept a config write.
REQ-008 cfg_chan  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-009 cfg_mode  input  2  mode_t: OFF=0, ON=1, BLINK=2, ONESHOT=3.
REQ-010 cfg_period  input  CNT_W  terminal count; phase length = cfg_period+1 cycles.
REQ-011 cfg_err  output  1  one-cycle pulse: accepted write had cfg_chan >= NUM_CH.
REQ-012 dim_level  input  DIM_W  global brightness; present only with LED_DIM_EN.
REQ-013 led  output  NUM_CH  LED drive, one bit per channel, registered.
REQ-014 done  output  NUM_CH  one-cycle pulse per channel when ONESHOT completes.

Function
REQ-015 Write accepted on the rising edge where cfg_valid && cfg_ready; cfg_ready SHALL be 1 in every cycle except while rst=1.
REQ-016 Accepted write in cycle T to a valid channel: mode, period loaded, channel counter cleared to 0; new led level visible at T+1.
REQ-017 Write initial led level: OFF->0, ON->1, BLINK->1, ONESHOT->1.
REQ-018 OFF/ON: counter held at 0, led constant.
REQ-019 BLINK: counter increments by 1 per cycle; when counter == period, counter->0 and led toggles; period=0 toggles every cycle; full period = 2*(period+1) cycles.
REQ-020 ONESHOT: led=1 for exactly period+1 cycles, then led->0, mode->OFF, done pulses high for that one cycle (same edge led falls).
REQ-021 Counter never exceeds period; no CNT_W overflow path exists (period = all-ones wraps to 0 cleanly).
REQ-022 Write to a channel mid-pattern aborts it immediately per REQ-016; an aborted ONESHOT SHALL NOT pulse done.
REQ-023 Write on the same cycle a ONESHOT would complete: write wins, no done pulse.
REQ-024 Write with cfg_chan >= NUM_CH: no channel state changes, cfg_err=1 at T+1 for one cycle.
REQ-025 Channels are fully independent; a write affects only the addressed channel.

Reset
REQ-026 rst=1 on an edge: all channels mode OFF, counters 0, led=0, done=0, cfg_err=0, dim counter 0, cfg_ready=0.
REQ-027 rst overrides a simultaneous cfg write; first write accepted is on the first edge with rst=0.

Configuration
REQ-028 Macro LED_DIM_EN defined: free-running DIM_W-bit dim counter; led[i] = state[i] && (dim_cnt <= dim_level); dim_level all-ones = full on, 0 = duty 1/2^DIM_W.
REQ-029 LED_DIM_EN undefined: no dim_level port, no dim counter; led[i] = state[i].

Structure
REQ-030 Package led_pkg SHALL hold mode_t enum and default NUM_CH/CNT_W/DIM_W constants.
REQ-031 Per-channel counter/mode FSM SHALL be sub-module led_chan, instantiated NUM_CH times via generate; dimming and cfg decode live in top.

Verification
REQ-032 rst 3 cycles -> led=0, done=0, cfg_ready=0; release -> cfg_ready=1 next cycle.
REQ-033 ch1 BLINK period=3 -> led[1] 1 for 4 cycles, 0 for 4, repeating; other channels stay 0.
REQ-034 ch0 ONESHOT period=5 -> led[0]=1 for 6 cycles, done[0] single pulse on fall, mode OFF after.
REQ-035 ch2 ONESHOT period=10, rewrite ON at cycle 4 -> led[2] stays 1, no done pulse.
REQ-036 cfg_chan=NUM_CH write -> cfg_err pulse 1 cycle, led unchanged.
REQ-037 LED_DIM_EN, DIM_W=4, ch0 ON, dim_level=3 -> led[0] high 4 of every 16 cycles; dim_level=15 -> constant 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared mode encoding, default sizing and helpers for the LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DIM_W  = 4;

    // A single channel still needs a one-bit select so the port never collapses to zero width.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode register, period counter and on/off level with ONESHOT completion pulse.
module led_chan
    import led_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  mode_t            wr_mode,
    input  logic [CNT_W-1:0] wr_period,
    output logic             lvl,
    output logic             done
);

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             done_q, done_d;
    logic             at_end;

    // A write always wins over the running pattern, so an aborted ONESHOT never reports done.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        lvl_d    = lvl_q;
        done_d   = 1'b0;
        at_end   = (cnt_q == period_q);

        if (wr_en) begin
            mode_d   = wr_mode;
            period_d = wr_period;
            cnt_d    = '0;
            lvl_d    = (wr_mode != MODE_OFF);
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (at_end) begin
                        cnt_d = '0;
                        lvl_d = ~lvl_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MODE_ONESHOT: begin
                    if (at_end) begin
                        cnt_d  = '0;
                        lvl_d  = 1'b0;
                        mode_d = MODE_OFF;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            cnt_q    <= '0;
            lvl_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            done_q   <= done_d;
        end
    end

    assign lvl  = lvl_q;
    assign done = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: config decode, per-channel pattern engines, optional global dimming.
// Define LED_DIM_EN to add the dim_level port and the free-running PWM dimming counter.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DIM_W  = DEF_DIM_W,
    localparam int CHAN_W = chan_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic              cfg_err,
`ifdef LED_DIM_EN
    input  logic [DIM_W-1:0]  dim_level,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] done
);

    logic              accept;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] state;
    logic              err_q, err_d;

    // Ready is only withheld during reset, so the first post-reset edge can already take a write.
    assign cfg_ready = !rst;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = accept && (cfg_chan == CHAN_W'(i));
        end
    end

    // An accepted write that selected no channel is an out-of-range index.
    always_comb err_d = accept && (wr_en == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en[g]),
            .wr_mode   (mode_t'(cfg_mode)),
            .wr_period (cfg_period),
            .lvl       (state[g]),
            .done      (done[g])
        );
    end

`ifdef LED_DIM_EN
    logic [DIM_W-1:0] dim_cnt_q, dim_cnt_d;

    always_comb dim_cnt_d = dim_cnt_q + DIM_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            dim_cnt_q <= '0;
        end else begin
            dim_cnt_q <= dim_cnt_d;
        end
    end

    always_comb led = state & {NUM_CH{dim_cnt_q <= dim_level}};
`else
    assign led = state;
`endif

endmodule
